// File: rtl/seven_segment_scanner_pkg.sv
// rtl/seven_segment_scanner_pkg.sv - segment bit positions and hex font shared by the scanner.
package seven_segment_scanner_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_F = 5;
  localparam int SEG_E = 4;
  localparam int SEG_D = 3;
  localparam int SEG_C = 2;
  localparam int SEG_B = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] S_A = 7'b1 << SEG_A;
  localparam logic [SEG_W-1:0] S_F = 7'b1 << SEG_F;
  localparam logic [SEG_W-1:0] S_E = 7'b1 << SEG_E;
  localparam logic [SEG_W-1:0] S_D = 7'b1 << SEG_D;
  localparam logic [SEG_W-1:0] S_C = 7'b1 << SEG_C;
  localparam logic [SEG_W-1:0] S_B = 7'b1 << SEG_B;
  localparam logic [SEG_W-1:0] S_G = 7'b1 << SEG_G;

  // Active-high font; lowercase b and d keep them distinct from 8 and 0.
  function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] nib);
    hex_font = '0;
    case (nib)
      4'h0: hex_font = S_A | S_B | S_C | S_D | S_E | S_F;
      4'h1: hex_font = S_B | S_C;
      4'h2: hex_font = S_A | S_B | S_D | S_E | S_G;
      4'h3: hex_font = S_A | S_B | S_C | S_D | S_G;
      4'h4: hex_font = S_B | S_C | S_F | S_G;
      4'h5: hex_font = S_A | S_C | S_D | S_F | S_G;
      4'h6: hex_font = S_A | S_C | S_D | S_E | S_F | S_G;
      4'h7: hex_font = S_A | S_B | S_C;
      4'h8: hex_font = S_A | S_B | S_C | S_D | S_E | S_F | S_G;
      4'h9: hex_font = S_A | S_B | S_C | S_D | S_F | S_G;
      4'hA: hex_font = S_A | S_B | S_C | S_E | S_F | S_G;
      4'hB: hex_font = S_C | S_D | S_E | S_F | S_G;
      4'hC: hex_font = S_A | S_D | S_E | S_F;
      4'hD: hex_font = S_B | S_C | S_D | S_E | S_G;
      4'hE: hex_font = S_A | S_D | S_E | S_F | S_G;
      4'hF: hex_font = S_A | S_E | S_F | S_G;
      default: hex_font = '0;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational nibble to active-high segment decode.
module seven_segment_decoder
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_font(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed 7-segment scanner with blanking, PWM and guard time.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD       = 16,
  parameter int PWM_BITS    = 3,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [SEG_W-1:0]      segments,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         index_q, index_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  frame_q, frame_d;

  logic                  slot_end, wrap;
  logic [3:0]            nibble;
  logic [SEG_W-1:0]      font_seg, seg_raw;
  logic [DIGITS-1:0]     nonzero_from, en_raw;
  logic                  digit_dp, blanked, in_window, dp_raw;
  logic [31:0]           on_len;

  seven_segment_decoder u_decoder (
    .nibble (nibble),
    .seg    (font_seg)
  );

  always_comb begin
    slot_end = (32'(presc_q) == 32'(SCAN_DIV - 1));
    wrap     = slot_end && (32'(index_q) == 32'(DIGITS - 1));
    presc_d  = slot_end ? '0 : presc_q + PW'(1);
    index_d  = index_q;
    if (slot_end) index_d = wrap ? '0 : index_q + IW'(1);
    bright_d = (presc_q == '0) ? brightness : bright_q;

    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    // Display only changes at the frame wrap; a load landing on that cycle bypasses pending.
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
    frame_d = wrap;
  end

  always_comb begin
    nibble   = '0;
    digit_dp = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_q == IW'(i)) begin
        nibble   = disp_val_q[4*i +: 4];
        digit_dp = disp_dp_q[i];
      end
    end

    // nonzero_from[i]: some nibble at position i or above is non-zero.
    nonzero_from = '0;
    nonzero_from[DIGITS-1] = |disp_val_q[4*DIGITS-1 -: 4];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      nonzero_from[i] = nonzero_from[i+1] | (|disp_val_q[4*i +: 4]);
    end
    blanked = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (index_q == IW'(i)) blanked = blank_lz && !nonzero_from[i];
    end

    on_len    = (32'(SCAN_DIV - GUARD) * (32'(bright_d) + 32'd1)) >> PWM_BITS;
    in_window = (32'(presc_q) >= 32'(GUARD)) && (32'(presc_q) < 32'(GUARD) + on_len);

    seg_raw = '0;
    dp_raw  = 1'b0;
    en_raw  = '0;
    if (in_window) begin
      seg_raw = blanked ? '0 : font_seg;
      dp_raw  = digit_dp;
      en_raw  = DIGITS'(1) << index_q;
    end
    seg_d      = seg_raw ^ {SEG_W{SEG_ACT_LOW}};
    dp_out_d   = dp_raw ^ SEG_ACT_LOW;
    digit_en_d = en_raw ^ {DIGITS{DIG_ACT_LOW}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      index_q      <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      bright_q     <= '0;
      seg_q        <= {SEG_W{SEG_ACT_LOW}};
      dp_out_q     <= SEG_ACT_LOW;
      digit_en_q   <= {DIGITS{DIG_ACT_LOW}};
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      index_q      <= index_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      bright_q     <= bright_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      digit_en_q   <= digit_en_d;
      frame_q      <= frame_d;
    end
  end

  assign segments = seg_q;
  assign dp_out   = dp_out_q;
  assign digit_en = digit_en_q;
  assign frame    = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [6:0]  segments;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame;

  int checks   = 0;
  int failures = 0;
  int c;

  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp;
  logic        p_valid;
  int          m_bright;

  seven_segment_scanner #(
    .DIGITS(4), .SCAN_DIV(8), .GUARD(1), .PWM_BITS(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .blank_lz(blank_lz),
    .brightness(brightness), .segments(segments), .dp_out(dp_out), .digit_en(digit_en), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Glyphs as lists of lit segment letters; pin order is a f e d c b g from bit 6 down.
  function automatic logic [6:0] ref_font(input int n);
    string s;
    string order;
    logic [6:0] r;
    order = "afedcbg";
    r = '0;
    case (n)
      0: s = "abcdef";   1: s = "bc";     2: s = "abdeg";  3: s = "abcdg";
      4: s = "bcfg";     5: s = "acdfg";  6: s = "acdefg"; 7: s = "abc";
      8: s = "abcdefg";  9: s = "abcdfg"; 10: s = "abcefg"; 11: s = "cdefg";
      12: s = "adef";    13: s = "bcdeg"; 14: s = "adefg"; default: s = "aefg";
    endcase
    for (int k = 0; k < s.len(); k++)
      for (int j = 0; j < 7; j++)
        if (order[j] == s[k]) r[6-j] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; p_valid = 1'b0; m_bright = 0;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_segments"}, 32'(segments), 32'h7F);
    check({tag, "_dp_out"},   32'(dp_out),   32'h1);
    check({tag, "_digit_en"}, 32'(digit_en), 32'hF);
    check({tag, "_frame"},    32'(frame),    32'h0);
  endtask

  // One clock: predict the registered outputs for cycle c, advance, then compare.
  task automatic tick();
    int p, idx, on;
    logic win, blk, wrap, e_dp;
    logic [15:0] sh;
    logic [6:0] e_seg;
    logic [3:0] e_en;
    p   = c % 8;
    idx = (c / 8) % 4;
    if (p == 0) m_bright = int'(brightness);
    on  = (7 * (m_bright + 1)) >> 2;
    win = (p >= 1) && (p < 1 + on);
    sh  = m_val >> (4 * idx);
    blk = blank_lz && (idx > 0) && (sh == 16'd0);
    e_seg = ~((win && !blk) ? ref_font(int'(sh[3:0])) : 7'd0);
    e_dp  = ~(win && m_dp[idx]);
    e_en  = ~(win ? (4'b0001 << idx) : 4'b0000);
    wrap  = (c % 32) == 31;
    if (wrap) begin
      if (load) begin
        m_val = value; m_dp = dp;
      end else if (p_valid) begin
        m_val = p_val; m_dp = p_dp;
      end
      p_valid = 1'b0;
    end else if (load) begin
      p_val = value; p_dp = dp; p_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("segments", 32'(segments), 32'(e_seg));
    check("dp_out",   32'(dp_out),   32'(e_dp));
    check("digit_en", 32'(digit_en), 32'(e_en));
    check("frame",    32'(frame),    32'(wrap));
    check("onehot",   32'($countones(~digit_en) <= 1), 32'h1);
    load = 1'b0;
    c++;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0; brightness = 2'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_off("reset");
    reset = 1'b0;
    repeat (40) tick();

    while (c % 32 != 10) tick();
    value = 16'h1234; dp = 4'b0000; load = 1'b1;
    tick();
    repeat (60) tick();

    blank_lz = 1'b1; value = 16'h0050; load = 1'b1;
    tick();
    repeat (70) tick();
    value = 16'h0000; load = 1'b1;
    tick();
    repeat (70) tick();

    value = 16'h8888; load = 1'b1;
    tick();
    repeat (40) tick();
    while (c % 8 != 4) tick();
    brightness = 2'd0;
    repeat (40) tick();
    brightness = 2'd2;
    repeat (20) tick();

    brightness = 2'd3;
    while (c % 32 != 31) tick();
    value = 16'hBEEF; dp = 4'b0001; load = 1'b1;
    tick();
    repeat (70) tick();

    value = 16'h0003; dp = 4'b0100; blank_lz = 1'b1; load = 1'b1;
    tick();
    repeat (70) tick();

    repeat (400) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp    = 4'($urandom);
        load  = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      tick();
    end

    brightness = 2'd3; blank_lz = 1'b0;
    while (c % 8 != 3) tick();
    #2 reset = 1'b1;
    #1;
    check_off("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_off("held_reset");
    reset = 1'b0;
    model_reset();
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
